// File: rtl/rr_resource_scheduler.sv
// -----------------------------------------------------------------------------
// rr_resource_scheduler
//
// Purpose:
//   Shares one downstream resource between N requesters in round-robin order.
//   A granted requester keeps ownership until it signals done or drops its
//   request. With the optional quota, it also loses ownership when it is
//   preempted. Every change of owner is followed by a one-cycle turnaround
//   gap, so grant is low for two cycles between owners.
//
// Optional feature:
//   GRANT_QUOTA_EN - when defined, an owner that has held the resource for
//   QUOTA cycles is preempted as soon as another requester is pending.
//   Preemption is reported as a one-cycle pulse on preempt.
//   When undefined, preempt is tied low and ownership is never forced off.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   req[N]       in   level request per requester
//   done         in   owner finished (only looked at while owning)
//   grant[N]     out  registered one-hot grant
//   grant_valid  out  high iff grant != 0
//   grant_idx    out  binary index of the owner, 0 when idle
//   preempt      out  one-cycle pulse in the gap that follows a quota release
//   state_dbg    out  current FSM state (0 IDLE, 1 OWN, 2 GAP)
//
// Handshake:
//   req is a level held for the whole ownership. grant follows req with one
//   cycle of latency. Ownership ends at the first edge that sees done=1 or
//   req[owner]=0. A release and a done on the same edge count as one release.
// -----------------------------------------------------------------------------
module rr_resource_scheduler #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int QUOTA = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             preempt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state;

  // One-hot priority pointer: the search for the next owner starts here.
  logic [N-1:0] ptr;

  logic [IDX_W-1:0] ptr_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [N-1:0]     win_onehot;
  logic             win_found;
  int               pos;

  logic             owner_req;
  logic             release_now;
  logic             others_pending;
  logic             quota_hit;
  logic [N-1:0]     next_ptr;

  assign state_dbg = state;

  // Convert the one-hot pointer into a binary index.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) ptr_idx = IDX_W'(i);
    end
  end

  // Round-robin search: start at ptr_idx, walk toward the MSB, wrap to bit 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    pos       = 0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_idx) + i;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot     = {{(N-1){1'b0}}, 1'b1} << win_idx;
  assign owner_req      = req[grant_idx];
  assign release_now    = done | ~owner_req;
  assign others_pending = |(req & ~grant);

  // The requester after the owner gets top priority next time.
  assign next_ptr = {grant[N-2:0], grant[N-1]};

`ifdef GRANT_QUOTA_EN
  localparam int CNT_W = $clog2(QUOTA);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUOTA - 1);

  // Counts owned cycles. It saturates at QUOTA-1 while nobody else waits.
  logic [CNT_W-1:0] cnt;

  assign quota_hit = (cnt == CNT_LAST) && others_pending;
`else
  assign quota_hit = 1'b0;
  assign preempt   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= {{(N-1){1'b0}}, 1'b1};
`ifdef GRANT_QUOTA_EN
      cnt         <= '0;
      preempt     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef GRANT_QUOTA_EN
          preempt <= 1'b0;
`endif
          if (win_found) begin
            grant       <= win_onehot;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            state       <= OWN;
`ifdef GRANT_QUOTA_EN
            cnt         <= '0;
`endif
          end
        end

        OWN: begin
          if (release_now || quota_hit) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= next_ptr;
            state       <= GAP;
`ifdef GRANT_QUOTA_EN
            // A normal release masks the preemption report.
            preempt     <= quota_hit & ~release_now;
`endif
          end
`ifdef GRANT_QUOTA_EN
          else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        GAP: begin
          state <= IDLE;
`ifdef GRANT_QUOTA_EN
          preempt <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_resource_scheduler.sv
module tb_rr_resource_scheduler;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int QUOTA = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             preempt;
  logic [1:0]       state_dbg;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     exp_grant;
    logic [IDX_W-1:0] exp_idx;
    logic [1:0]       exp_state;
  } vec_t;

  vec_t vecs[$];

  rr_resource_scheduler #(.N(N), .IDX_W(IDX_W), .QUOTA(QUOTA)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .preempt     (preempt),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, then check the outputs after the edge.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic d,
                      input logic [N-1:0] eg, input logic [IDX_W-1:0] ei,
                      input logic [1:0] es, input logic ep, input string tag);
    reset = rst;
    req   = r;
    done  = d;
    @(posedge clk);
    #1;
    cmp({tag, " grant"},       32'(grant),       32'(eg));
    cmp({tag, " grant_idx"},   32'(grant_idx),   32'(ei));
    cmp({tag, " grant_valid"}, 32'(grant_valid), 32'(eg != '0));
    cmp({tag, " preempt"},     32'(preempt),     32'(ep));
    cmp({tag, " state"},       32'(state_dbg),   32'(es));
    cmp({tag, " onehot"},      32'($onehot0(grant)), 32'd1);
  endtask

  function automatic vec_t mk(input logic rst, input logic [N-1:0] r, input logic d,
                              input logic [N-1:0] eg, input logic [IDX_W-1:0] ei,
                              input logic [1:0] es);
    vec_t v;
    v.rst = rst; v.req = r; v.done = d;
    v.exp_grant = eg; v.exp_idx = ei; v.exp_state = es;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;

    // Reset and single requester with done
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, S_OWN));
    vecs.push_back(mk(0, 4'b0001, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, S_IDLE));
    // ptr is now bit1: req 0011 picks requester 1
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0010, 1, S_OWN));
    vecs.push_back(mk(0, 4'b0011, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, S_OWN));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, S_GAP));
    // All requesting: rotation 1, 2, 3, 0 with two low cycles between owners
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, S_OWN));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, S_OWN));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, S_OWN));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b1000, 3, S_OWN));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, S_OWN));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, S_IDLE));
    // Wrap/skip: owner 3 releases, then 0110 gives 1, then 2
    vecs.push_back(mk(0, 4'b1000, 0, 4'b1000, 3, S_OWN));
    vecs.push_back(mk(0, 4'b0110, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0110, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0110, 0, 4'b0010, 1, S_OWN));
    vecs.push_back(mk(0, 4'b0110, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0110, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0110, 0, 4'b0100, 2, S_OWN));
    // Owner 2 drops req: release; search from bit3 wraps to bit0
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, S_OWN));
    // done in GAP/IDLE ignored; request dropped before sampling never granted
    vecs.push_back(mk(0, 4'b0011, 1, 4'b0000, 0, S_GAP));
    vecs.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, S_IDLE));
    // Reset mid-ownership, then fresh grant from ptr bit0
    vecs.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, S_OWN));
    vecs.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, S_OWN));
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 0, S_IDLE));
    vecs.push_back(mk(0, 4'b1000, 0, 4'b1000, 3, S_OWN));
    vecs.push_back(mk(0, 4'b1000, 1, 4'b0000, 0, S_GAP));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].exp_grant,
           vecs[i].exp_idx, vecs[i].exp_state, 1'b0, $sformatf("v%0d", i));
    end

    // Two requesters held with no done: quota behaviour (ptr is bit0 here)
    step(0, 4'b0011, 0, 4'b0000, 0, S_IDLE, 0, "q_gap_exit");
    step(0, 4'b0011, 0, 4'b0001, 0, S_OWN, 0, "q_first");
`ifdef GRANT_QUOTA_EN
    for (int k = 1; k < QUOTA; k++)
      step(0, 4'b0011, 0, 4'b0001, 0, S_OWN, 0, $sformatf("q_own0_%0d", k));
    step(0, 4'b0011, 0, 4'b0000, 0, S_GAP, 1, "q_preempt0");
    step(0, 4'b0011, 0, 4'b0000, 0, S_IDLE, 0, "q_idle0");
    for (int k = 0; k < QUOTA; k++)
      step(0, 4'b0011, 0, 4'b0010, 1, S_OWN, 0, $sformatf("q_own1_%0d", k));
    step(0, 4'b0011, 0, 4'b0000, 0, S_GAP, 1, "q_preempt1");
    // Lone requester: held past the quota, no preemption
    step(0, 4'b0001, 0, 4'b0000, 0, S_IDLE, 0, "q_idle1");
    step(0, 4'b0001, 0, 4'b0001, 0, S_OWN, 0, "q_lone_grant");
    for (int k = 0; k < 10; k++)
      step(0, 4'b0001, 0, 4'b0001, 0, S_OWN, 0, $sformatf("q_lone_%0d", k));
    // Saturated counter, other pending, but done wins: no preempt pulse
    step(0, 4'b0011, 1, 4'b0000, 0, S_GAP, 0, "q_done_wins");
    step(0, 4'b0000, 0, 4'b0000, 0, S_IDLE, 0, "q_end");
`else
    for (int k = 0; k < 10; k++)
      step(0, 4'b0011, 0, 4'b0001, 0, S_OWN, 0, $sformatf("nq_hold_%0d", k));
    step(0, 4'b0000, 0, 4'b0000, 0, S_GAP, 0, "nq_drop");
    step(0, 4'b0000, 0, 4'b0000, 0, S_IDLE, 0, "nq_end");
`endif

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
